// File: rtl/frame_tx_pkg.sv
// Shared definitions for the camera-style pixel stream transmitter.
// Holds the FSM state encoding, RGB565 colour constants and default timing.
// Also holds the colour-bar lookup used by the optional test-pattern generator.
package frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } tx_state_t;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_BLANK    = 160;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 20;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_CONTINUOUS = 1;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_SKIN    = 16'hFB2C;

    // Colour of vertical bar idx, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/frame_tx_timing.sv
// Frame/line timing: h/v counters and the VSYNC/VBACK/ACTIVE/VFRONT state machine.
// Latency: flags are combinational from the current counter cycle.
// Backpressure: none; timing free-runs once a frame starts and is never stretched.
module frame_tx_timing
    import frame_tx_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int CONTINUOUS = DEF_CONTINUOUS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [2:0]  state,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        pix_slot,
    output logic        frame_last,
    output logic        frame_start
);

    localparam logic [11:0] LINE_LAST = 12'(H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0] HA        = 12'(H_ACTIVE);
    localparam logic [11:0] VS_LAST   = 12'(V_SYNC - 1);
    localparam logic [11:0] VB_LAST   = 12'(V_BACK - 1);
    localparam logic [11:0] VA_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VF_LAST   = 12'(V_FRONT - 1);

    tx_state_t   cur, nxt;
    logic [11:0] last_line;
    logic        line_end;
    logic        state_end;

    // Index of the final line of the current state (v_cnt is per-state).
    always_comb begin
        last_line = 12'd0;
        case (cur)
            ST_VSYNC:  last_line = VS_LAST;
            ST_VBACK:  last_line = VB_LAST;
            ST_ACTIVE: last_line = VA_LAST;
            ST_VFRONT: last_line = VF_LAST;
            default:   last_line = 12'd0;
        endcase
    end

    assign line_end   = (h_cnt == LINE_LAST);
    assign state_end  = line_end && (v_cnt == last_line);
    assign pix_slot   = (cur == ST_ACTIVE) && (h_cnt < HA);
    assign frame_last = (cur == ST_VFRONT) && state_end;
    assign state      = cur;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= ST_IDLE;
        else        cur <= nxt;
    end

    // Next state; frame_start marks the edge that opens a new frame.
    always_comb begin
        nxt         = cur;
        frame_start = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (start) begin
                    nxt         = ST_VSYNC;
                    frame_start = 1'b1;
                end
            end
            ST_VSYNC:  if (state_end) nxt = ST_VBACK;
            ST_VBACK:  if (state_end) nxt = ST_ACTIVE;
            ST_ACTIVE: if (state_end) nxt = ST_VFRONT;
            ST_VFRONT: begin
                if (state_end) begin
                    if ((CONTINUOUS != 0) && start) begin
                        nxt         = ST_VSYNC;
                        frame_start = 1'b1;
                    end else begin
                        nxt = ST_IDLE;
                    end
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Pixel and line counters; held at zero in IDLE so a new frame starts at 0/0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (cur == ST_IDLE) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (line_end) begin
            h_cnt <= 12'd0;
            v_cnt <= state_end ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

endmodule

// File: rtl/frame_stream_tx.sv
// Camera-replacement transmitter: vsync/href/clken timing plus RGB565 pixels from a ready/valid source.
// Latency: all video outputs registered, one cycle after the internal timing cycle.
// Backpressure: none toward the sink; a starved pixel slot emits black and counts underflow. Optional FRAME_TX_PATTERN_EN.
module frame_stream_tx
    import frame_tx_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int CONTINUOUS = DEF_CONTINUOUS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        out_frame_vsync,
    output logic        out_frame_href,
    output logic        out_frame_clken,
    output logic [15:0] out_image,
    output logic        frame_done,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    logic [2:0]  state;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        pix_slot;
    logic        frame_last;
    logic        frame_start;
    logic        pat_on;
    logic [15:0] pat_pix;
    logic        starve;

    frame_tx_timing #(
        .H_ACTIVE   (H_ACTIVE),
        .H_BLANK    (H_BLANK),
        .V_SYNC     (V_SYNC),
        .V_BACK     (V_BACK),
        .V_ACTIVE   (V_ACTIVE),
        .V_FRONT    (V_FRONT),
        .CONTINUOUS (CONTINUOUS)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .state       (state),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .pix_slot    (pix_slot),
        .frame_last  (frame_last),
        .frame_start (frame_start)
    );

`ifdef FRAME_TX_PATTERN_EN
    // Bars narrower than one pixel are clamped so tiny test geometries still work.
    localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

    logic [11:0] bar_idx;
    logic        unused_vcnt;

    assign pat_on      = (pattern_sel != 2'd0);
    assign bar_idx     = h_cnt / 12'(BAR_W);
    assign unused_vcnt = ^v_cnt;

    // Internal test-pattern pixel for the current slot; v_cnt is the active-line index.
    always_comb begin
        pat_pix = RGB_BLACK;
        case (pattern_sel)
            2'd1:    pat_pix = bar_colour((bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0]);
            2'd2:    pat_pix = RGB_SKIN;
            2'd3:    pat_pix = (h_cnt[4] ^ v_cnt[4]) ? RGB_BLACK : RGB_WHITE;
            default: pat_pix = RGB_BLACK;
        endcase
    end
`else
    logic unused_pattern;

    assign pat_on         = 1'b0;
    assign pat_pix        = RGB_BLACK;
    assign unused_pattern = ^{pattern_sel, h_cnt, v_cnt};
`endif

    // The source is only offered slots while it is actually the pixel origin.
    assign src_ready = pix_slot && !pat_on;
    assign starve    = src_ready && !src_valid;

    // Registered video outputs, one cycle behind the timing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_frame_vsync <= 1'b0;
            out_frame_href  <= 1'b0;
            out_frame_clken <= 1'b0;
            out_image       <= 16'h0000;
            frame_done      <= 1'b0;
        end else begin
            out_frame_vsync <= (state == ST_VSYNC);
            out_frame_href  <= pix_slot;
            out_frame_clken <= pix_slot;
            if (pat_on)
                out_image <= pix_slot ? pat_pix : RGB_BLACK;
            else
                out_image <= src_valid ? src_data : RGB_BLACK;
            frame_done      <= frame_last;
        end
    end

    // Sticky starvation flag and saturating per-frame count, cleared as each frame opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow     <= 1'b0;
            underflow_cnt <= 16'h0000;
        end else if (frame_start) begin
            underflow     <= 1'b0;
            underflow_cnt <= 16'h0000;
        end else if (starve) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx with a tiny 4x3 geometry (36-cycle frame).
// Instance 0 is built with CONTINUOUS=0, instance 1 with CONTINUOUS=1.
// Expected outputs come from a frame-position model computed per output cycle.
module tb_frame_stream_tx;

    localparam int HA = 4, HB = 2, VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int L    = HA + HB;
    localparam int FL   = (VS + VB + VA + VF) * L;
    localparam int MAXC = 2 * FL + 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        start [2];
    logic        src_valid [2];
    logic [15:0] src_data [2];
    logic        src_ready [2];
    logic        vs [2];
    logic        href [2];
    logic        clken [2];
    logic [15:0] img [2];
    logic        done [2];
    logic        uf [2];
    logic [15:0] ufc [2];

    int tests = 0;
    int fails = 0;

    bit          vpat [0:MAXC];
    logic [15:0] words [0:63];

    logic        o_rdy [0:MAXC];
    logic        o_vs [0:MAXC];
    logic        o_href [0:MAXC];
    logic        o_clk [0:MAXC];
    logic        o_done [0:MAXC];
    logic        o_uf [0:MAXC];
    logic [15:0] o_img [0:MAXC];
    logic [15:0] o_ufc [0:MAXC];

    logic        e_slot [0:MAXC];
    logic        e_vs [0:MAXC];
    logic        e_done [0:MAXC];
    logic [15:0] e_img [0:MAXC];
    logic [15:0] e_ufc [0:MAXC];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        frame_stream_tx #(
            .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
            .V_ACTIVE(VA), .V_FRONT(VF), .CONTINUOUS(g)
        ) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start[g]),
            .pattern_sel     (pattern_sel),
            .src_valid       (src_valid[g]),
            .src_data        (src_data[g]),
            .src_ready       (src_ready[g]),
            .out_frame_vsync (vs[g]),
            .out_frame_href  (href[g]),
            .out_frame_clken (clken[g]),
            .out_image       (img[g]),
            .frame_done      (done[g]),
            .underflow       (uf[g]),
            .underflow_cnt   (ufc[g])
        );
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural frame model: output k (after edge k) from its position in the frame.
    task automatic model(input int n, input bit restart);
        int acc = 0;
        int starved = 0;
        for (int k = 1; k <= n; k++) begin
            int f, line, col;
            bit live;
            f    = (k - 1) % FL;
            line = f / L;
            col  = f % L;
            live = restart || (k <= FL);
            e_slot[k] = live && line >= VS + VB && line < VS + VB + VA && col < HA;
            e_vs[k]   = live && line < VS;
            e_done[k] = live && f == FL - 1;
            e_img[k]  = vpat[k] ? words[acc] : 16'h0000;
            if (e_slot[k]) begin
                if (vpat[k]) acc++;
                else         starved++;
            end
            if (restart && f == FL - 1) starved = 0;
            e_ufc[k] = 16'(starved);
        end
    endtask

    // Source + frame driver: start is seen at edge 0, then n cycles are recorded.
    task automatic run(input int inst, input int n, input bit hold);
        int wi = 0;
        @(negedge clk);
        start[inst] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (!hold) start[inst] = 1'b0;
            src_valid[inst] = vpat[c];
            src_data[inst]  = words[wi];
            o_rdy[c]        = src_ready[inst];
            @(posedge clk);
            if (o_rdy[c] && vpat[c] && wi < 63) wi++;
            #1;
            o_vs[c]   = vs[inst];
            o_href[c] = href[inst];
            o_clk[c]  = clken[inst];
            o_img[c]  = img[inst];
            o_done[c] = done[inst];
            o_uf[c]   = uf[inst];
            o_ufc[c]  = ufc[inst];
        end
        start[inst]     = 1'b0;
        src_valid[inst] = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({src_ready[i], vs[i], href[i], clken[i], done[i], uf[i]} !== 6'b0 ||
                img[i] !== 16'h0 || ufc[i] !== 16'h0) begin
                fails++;
                $display("FAIL reset inst%0d: rdy%b vs%b href%b clk%b done%b uf%b img%h cnt%h, all zero required",
                         i, src_ready[i], vs[i], href[i], clken[i], done[i], uf[i], img[i], ufc[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame_timing();
        int nvs = 0, nclk = 0, npix = 0;
        for (int c = 0; c <= MAXC; c++) vpat[c] = 1'b1;
        for (int i = 0; i < 64; i++) words[i] = 16'(i);
        run(0, FL + 4, 1'b0);
        model(FL + 4, 1'b0);
        for (int k = 1; k <= FL + 4; k++) begin
            tests++;
            if (o_vs[k] !== e_vs[k] || o_clk[k] !== e_slot[k] || o_href[k] !== e_slot[k] ||
                o_done[k] !== e_done[k] || o_rdy[k] !== e_slot[k]) begin
                fails++;
                $display("FAIL timing k=%0d: vs%b clk%b href%b done%b rdy%b, required vs%b strobe%b done%b",
                         k, o_vs[k], o_clk[k], o_href[k], o_done[k], o_rdy[k], e_vs[k], e_slot[k], e_done[k]);
            end
            if (o_vs[k] === 1'b1) nvs++;
            if (o_clk[k] === 1'b1) begin
                tests++;
                if (o_img[k] !== 16'(npix)) begin
                    fails++;
                    $display("FAIL data_order pixel %0d: got %h required %h", npix, o_img[k], 16'(npix));
                end
                npix++;
                nclk++;
            end
        end
        tests++;
        if (nvs != VS * L || nclk != HA * VA) begin
            fails++;
            $display("FAIL frame_counts: vsync %0d clken %0d, required %0d and %0d", nvs, nclk, VS * L, HA * VA);
        end
        tests++;
        if (o_uf[FL] !== 1'b0 || o_ufc[FL] !== 16'h0) begin
            fails++;
            $display("FAIL no_underflow: uf %b cnt %0d, required 0 and 0", o_uf[FL], o_ufc[FL]);
        end
    endtask

    task automatic test_underflow();
        int first = (VS + VB) * L + 1;
        for (int c = 0; c <= MAXC; c++) vpat[c] = 1'b1;
        vpat[first + 1] = 1'b0;
        vpat[first + 2] = 1'b0;
        for (int i = 0; i < 64; i++) words[i] = 16'($urandom_range(1, 16'hFFFF));
        run(0, FL + 2, 1'b0);
        model(FL + 2, 1'b0);
        for (int k = 1; k <= FL + 2; k++) begin
            tests++;
            if (o_clk[k] !== e_slot[k] || (e_slot[k] && o_img[k] !== e_img[k]) || o_done[k] !== e_done[k]) begin
                fails++;
                $display("FAIL underflow_stream k=%0d: clk%b img %h done%b, required clk%b img %h done%b",
                         k, o_clk[k], o_img[k], o_done[k], e_slot[k], e_img[k], e_done[k]);
            end
        end
        tests++;
        if (o_clk[first + 1] !== 1'b1 || o_img[first + 1] !== 16'h0 || o_img[first + 2] !== 16'h0) begin
            fails++;
            $display("FAIL starved_pixels: clk%b img %h %h, required clk1 and 0000 0000",
                     o_clk[first + 1], o_img[first + 1], o_img[first + 2]);
        end
        tests++;
        if (o_uf[FL + 2] !== 1'b1 || o_ufc[FL + 2] !== 16'd2) begin
            fails++;
            $display("FAIL underflow_count: uf %b cnt %0d, required 1 and 2", o_uf[FL + 2], o_ufc[FL + 2]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c <= MAXC; c++) vpat[c] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
            run(0, FL + 3, 1'b0);
            model(FL + 3, 1'b0);
            for (int k = 1; k <= FL + 3; k++) begin
                tests++;
                if (o_vs[k] !== e_vs[k] || o_clk[k] !== e_slot[k] || o_rdy[k] !== e_slot[k] ||
                    o_img[k] !== e_img[k] || o_ufc[k] !== e_ufc[k] || o_uf[k] !== (e_ufc[k] != 0)) begin
                    fails++;
                    $display("FAIL random r%0d k=%0d: vs%b clk%b rdy%b img %h cnt %0d uf%b, required vs%b clk%b img %h cnt %0d",
                             r, k, o_vs[k], o_clk[k], o_rdy[k], o_img[k], o_ufc[k], o_uf[k],
                             e_vs[k], e_slot[k], e_img[k], e_ufc[k]);
                end
            end
        end
    endtask

    task automatic test_continuous();
        int n = FL + 12;
        for (int c = 0; c <= MAXC; c++) vpat[c] = ($urandom_range(0, 4) != 0);
        vpat[(VS + VB) * L + 1] = 1'b0;
        for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
        run(1, n, 1'b1);
        model(n, 1'b1);
        for (int k = 1; k <= n; k++) begin
            tests++;
            if (o_vs[k] !== e_vs[k] || o_clk[k] !== e_slot[k] || o_done[k] !== e_done[k] ||
                o_img[k] !== e_img[k] || o_ufc[k] !== e_ufc[k]) begin
                fails++;
                $display("FAIL continuous k=%0d: vs%b clk%b done%b img %h cnt %0d, required vs%b clk%b done%b img %h cnt %0d",
                         k, o_vs[k], o_clk[k], o_done[k], o_img[k], o_ufc[k],
                         e_vs[k], e_slot[k], e_done[k], e_img[k], e_ufc[k]);
            end
        end
        tests++;
        if (o_uf[FL - 1] !== 1'b1 || o_uf[FL] !== 1'b0 || o_vs[FL + 1] !== 1'b1) begin
            fails++;
            $display("FAIL continuous_restart: uf before %b at end %b vsync next %b, required 1 0 1",
                     o_uf[FL - 1], o_uf[FL], o_vs[FL + 1]);
        end
        repeat (FL) @(posedge clk);
    endtask

    task automatic test_stop_continuous();
        for (int c = 0; c <= MAXC; c++) vpat[c] = 1'b1;
        run(1, FL + 6, 1'b0);
        tests++;
        if (o_done[FL] !== 1'b1) begin
            fails++;
            $display("FAIL stop_done: got %b required 1", o_done[FL]);
        end
        for (int k = FL + 1; k <= FL + 6; k++) begin
            tests++;
            if (o_vs[k] !== 1'b0 || o_clk[k] !== 1'b0 || o_rdy[k] !== 1'b0 || o_done[k] !== 1'b0) begin
                fails++;
                $display("FAIL stop_idle k=%0d: vs%b clk%b rdy%b done%b, required all 0",
                         k, o_vs[k], o_clk[k], o_rdy[k], o_done[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int ndone = 0;
        for (int c = 0; c <= MAXC; c++) vpat[c] = 1'b1;
        for (int i = 0; i < 64; i++) words[i] = 16'(i + 100);
        run(0, (VS + VB) * L + 2, 1'b0);
        tests++;
        if (o_clk[(VS + VB) * L + 2] !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_active: clken %b required 1", o_clk[(VS + VB) * L + 2]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({vs[0], href[0], clken[0], done[0], src_ready[0]} !== 5'b0 || img[0] !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: vs%b href%b clk%b done%b rdy%b img %h, required all 0",
                     vs[0], href[0], clken[0], done[0], src_ready[0], img[0]);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done[0] === 1'b1) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(0, FL + 2, 1'b0);
        for (int k = 1; k <= FL + 2; k++) if (o_done[k] === 1'b1) ndone++;
        tests++;
        if (ndone != 1 || o_done[FL] !== 1'b1 || o_vs[1] !== 1'b1 || o_vs[VS * L + 1] !== 1'b0) begin
            fails++;
            $display("FAIL restart_frame: done pulses %0d done@end %b vs@1 %b vs after %b, required 1 1 1 0",
                     ndone, o_done[FL], o_vs[1], o_vs[VS * L + 1]);
        end
    endtask

    task automatic test_pattern();
        int npix = 0;
`ifdef FRAME_TX_PATTERN_EN
        int nrdy = 0;
        for (int c = 0; c <= MAXC; c++) vpat[c] = 1'b0;
        pattern_sel = 2'd2;
        run(0, FL, 1'b0);
        for (int k = 1; k <= FL; k++) begin
            if (o_rdy[k] === 1'b1) nrdy++;
            if (o_clk[k] === 1'b1) begin
                npix++;
                tests++;
                if (o_img[k] !== 16'hFB2C) begin
                    fails++;
                    $display("FAIL pattern_skin k=%0d: got %h required fb2c", k, o_img[k]);
                end
            end
        end
        tests++;
        if (npix != HA * VA || nrdy != 0 || o_ufc[FL] !== 16'h0) begin
            fails++;
            $display("FAIL pattern_ctrl: pixels %0d ready %0d cnt %0d, required %0d 0 0", npix, nrdy, o_ufc[FL], HA * VA);
        end
        pattern_sel = 2'd3;
        run(0, FL, 1'b0);
        tests++;
        if (o_clk[(VS + VB) * L + 1] !== 1'b1 || o_img[(VS + VB) * L + 1] !== 16'hFFFF) begin
            fails++;
            $display("FAIL pattern_checker: clk%b img %h, required 1 ffff",
                     o_clk[(VS + VB) * L + 1], o_img[(VS + VB) * L + 1]);
        end
`else
        for (int c = 0; c <= MAXC; c++) vpat[c] = 1'b1;
        for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
        pattern_sel = 2'd2;
        run(0, FL, 1'b0);
        for (int k = 1; k <= FL; k++) begin
            if (o_clk[k] === 1'b1) begin
                tests++;
                if (o_img[k] !== words[npix] || o_rdy[k] !== 1'b1) begin
                    fails++;
                    $display("FAIL pattern_ignored pixel %0d: got %h rdy %b, required %h rdy 1",
                             npix, o_img[k], o_rdy[k], words[npix]);
                end
                npix++;
            end
        end
`endif
        pattern_sel = 2'd0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i]     = 1'b0;
            src_valid[i] = 1'b0;
            src_data[i]  = 16'h0;
        end
        test_reset();
        test_frame_timing();
        test_underflow();
        test_random();
        test_continuous();
        test_stop_continuous();
        test_reset_mid_frame();
        test_pattern();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
